// File: rtl/ps2_pkg.sv
// Shared scan-code constants, host-response byte list and frame FSM states for the PS/2 receiver.
package ps2_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_PAUSE = 8'hE1;
  localparam logic [7:0] SC_UP    = 8'h1D;
  localparam logic [7:0] SC_DOWN  = 8'h1B;
  localparam logic [7:0] SC_LEFT  = 8'h1C;
  localparam logic [7:0] SC_RIGHT = 8'h23;

  // Pause sequence is E1 followed by seven bytes that carry no key meaning
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  // BAT result, ack, echo and error responses; never treated as key codes
  localparam int NUM_RESP = 8;
  localparam logic [NUM_RESP-1:0][7:0] RESP_CODES =
    {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } frame_state_e;

  function automatic logic is_response(input logic [7:0] b);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NUM_RESP; i++)
      if (RESP_CODES[i] == b) hit = 1'b1;
    return hit;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronises the PS/2 pins and glitch-filters the clock pin; strobes o_fall on a filtered 1->0.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_ps2_clk,
  input  logic i_ps2_dat,
  output logic o_fall,
  output logic o_dat
);

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [FW-1:0] CNT_MAX = FW'(FILTER_LEN - 1);

  logic [1:0]    r_clk_sync;
  logic [1:0]    r_dat_sync;
  logic          r_filt;
  logic [FW-1:0] r_cnt;
  logic          r_fall;

  // Sync stages and filter start at the bus idle level so reset never fakes an edge
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_clk_sync <= 2'b11;
      r_dat_sync <= 2'b11;
      r_filt     <= 1'b1;
      r_cnt      <= '0;
      r_fall     <= 1'b0;
    end else begin
      r_clk_sync <= {r_clk_sync[0], i_ps2_clk};
      r_dat_sync <= {r_dat_sync[0], i_ps2_dat};
      r_fall     <= 1'b0;
      if (r_clk_sync[1] == r_filt) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_MAX) begin
        r_filt <= r_clk_sync[1];
        r_cnt  <= '0;
        r_fall <= r_filt;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_fall = r_fall;
  assign o_dat  = r_dat_sync[1];

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: frame FSM, prefix/pause stripping, make-code pulses and held-key tracking.
// Optional PS2_AUTOREPEAT_EN adds a repeat timer that re-pulses the held key every REPEAT_CYCLES.
module ps2_scancode_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 10000,
  parameter int REPEAT_CYCLES  = 5000000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_dat,
  output logic [7:0] o_key,
  output logic       o_key_valid,
  output logic       o_ext,
  output logic [7:0] o_held,
  output logic       o_frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES - 1);

  logic w_fall;
  logic w_dat;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_ps2_clk (i_ps2_clk),
    .i_ps2_dat (i_ps2_dat),
    .o_fall    (w_fall),
    .o_dat     (w_dat)
  );

  frame_state_e  r_state;
  logic [2:0]    r_bitcnt;
  logic [7:0]    r_shift;
  logic          r_parbit;
  logic [TW-1:0] r_tmo;
  logic          r_ext_pend;
  logic          r_brk_pend;
  logic [2:0]    r_skip;
  logic [7:0]    r_held;
  logic          r_held_ext;
  logic [7:0]    r_key;
  logic          r_key_valid;
  logic          r_ext;
  logic          r_frame_err;

  logic w_stop_fall;
  logic w_accept;
  logic w_plain;
  logic w_make;
  logic w_release;

  // Decode happens in the stop-fall cycle so the pulse lands one cycle later
  always_comb begin
    w_stop_fall = w_fall && (r_state == ST_STOP);
    w_accept    = w_stop_fall && w_dat && (^{r_shift, r_parbit});
    w_plain     = w_accept && (r_skip == 3'd0) && (r_shift != SC_PAUSE) &&
                  (r_shift != SC_EXT) && (r_shift != SC_BREAK) && !is_response(r_shift);
    w_release   = w_plain && r_brk_pend;
    w_make      = w_plain && !r_brk_pend;
  end

`ifdef PS2_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RW-1:0] RPT_MAX = RW'(REPEAT_CYCLES - 1);
  logic [RW-1:0] r_rpt;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_bitcnt    <= '0;
      r_shift     <= '0;
      r_parbit    <= 1'b0;
      r_tmo       <= '0;
      r_ext_pend  <= 1'b0;
      r_brk_pend  <= 1'b0;
      r_skip      <= '0;
      r_held      <= '0;
      r_held_ext  <= 1'b0;
      r_key       <= '0;
      r_key_valid <= 1'b0;
      r_ext       <= 1'b0;
      r_frame_err <= 1'b0;
`ifdef PS2_AUTOREPEAT_EN
      r_rpt       <= '0;
`endif
    end else begin
      r_key       <= '0;
      r_key_valid <= 1'b0;
      r_ext       <= 1'b0;
      r_frame_err <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          // A fall with data high is line noise, not a start bit
          if (w_fall && !w_dat) begin
            r_state  <= ST_DATA;
            r_bitcnt <= '0;
          end
        end
        ST_DATA: begin
          if (w_fall) begin
            r_shift  <= {w_dat, r_shift[7:1]};
            r_bitcnt <= r_bitcnt + 1'b1;
            if (r_bitcnt == 3'd7) r_state <= ST_PARITY;
          end
        end
        ST_PARITY: begin
          if (w_fall) begin
            r_parbit <= w_dat;
            r_state  <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (w_fall) begin
            r_state <= ST_IDLE;
            if (!w_accept) begin
              r_frame_err <= 1'b1;
              r_ext_pend  <= 1'b0;
              r_brk_pend  <= 1'b0;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      // A fall in the expiry cycle still counts as progress
      if (r_state == ST_IDLE || w_fall) begin
        r_tmo <= '0;
      end else if (r_tmo == TMO_MAX) begin
        r_tmo       <= '0;
        r_state     <= ST_IDLE;
        r_frame_err <= 1'b1;
        r_ext_pend  <= 1'b0;
        r_brk_pend  <= 1'b0;
      end else begin
        r_tmo <= r_tmo + 1'b1;
      end

      if (w_accept) begin
        if (r_skip != 3'd0) begin
          r_skip <= r_skip - 1'b1;
        end else if (r_shift == SC_PAUSE) begin
          r_skip     <= PAUSE_SKIP;
          r_ext_pend <= 1'b0;
          r_brk_pend <= 1'b0;
        end else if (r_shift == SC_EXT) begin
          r_ext_pend <= 1'b1;
        end else if (r_shift == SC_BREAK) begin
          r_brk_pend <= 1'b1;
        end else begin
          r_ext_pend <= 1'b0;
          r_brk_pend <= 1'b0;
          // A release only clears the held key if it names that exact key
          if (w_release && ({r_ext_pend, r_shift} == {r_held_ext, r_held})) begin
            r_held     <= '0;
            r_held_ext <= 1'b0;
          end else if (w_make) begin
            r_key       <= r_shift;
            r_key_valid <= 1'b1;
            r_ext       <= r_ext_pend;
            r_held      <= r_shift;
            r_held_ext  <= r_ext_pend;
          end
        end
      end

`ifdef PS2_AUTOREPEAT_EN
      // Byte-derived pulses take priority and restart the period
      if (w_make || w_release || r_held == 8'h00) begin
        r_rpt <= '0;
      end else if (r_rpt == RPT_MAX) begin
        r_rpt       <= '0;
        r_key       <= r_held;
        r_key_valid <= 1'b1;
        r_ext       <= r_held_ext;
      end else begin
        r_rpt <= r_rpt + 1'b1;
      end
`endif
    end
  end

  assign o_key       = r_key;
  assign o_key_valid = r_key_valid;
  assign o_ext       = r_ext;
  assign o_held      = r_held;
  assign o_frame_err = r_frame_err;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Bench for ps2_scancode_rx: PS/2 frames at a scaled bit rate, checked against a scan-code model.
module tb_ps2_scancode_rx;

  localparam int HALF = 20;   // i_clk cycles per PS/2 half period (scaled down)
  localparam int FLT  = 4;
  localparam int TMO  = 200;
  localparam int RPT  = 1000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2c = 1'b1;
  logic       ps2d = 1'b1;
  logic [7:0] o_key;
  logic       o_key_valid;
  logic       o_ext;
  logic [7:0] o_held;
  logic       o_frame_err;

  always #10 clk = ~clk;

  ps2_scancode_rx #(
    .FILTER_LEN(FLT), .TIMEOUT_CYCLES(TMO), .REPEAT_CYCLES(RPT)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_ps2_clk(ps2c), .i_ps2_dat(ps2d),
    .o_key(o_key), .o_key_valid(o_key_valid), .o_ext(o_ext),
    .o_held(o_held), .o_frame_err(o_frame_err)
  );

  typedef struct {
    bit       err;
    bit [7:0] key;
    bit       ext;
  } ev_t;

  ev_t      evq[$];
  int       checks = 0;
  int       fails = 0;
  int       n_pulse = 0;
  int       n_err = 0;
  int       n_rep = 0;
  bit       run_chk = 0;
  int       m_skip = 0;
  bit       m_ext = 0, m_brk = 0;
  bit [7:0] m_held = 0, m_held_prev = 0;
  bit       m_hext = 0, m_hext_prev = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scan-code rules applied to one accepted byte
  function automatic void model_byte(input bit [7:0] b);
    ev_t e;
    m_held_prev = m_held;
    m_hext_prev = m_hext;
    if (m_skip > 0) m_skip--;
    else if (b == 8'hE1) begin m_skip = 7; m_ext = 0; m_brk = 0; end
    else if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else if (b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF}) begin
      m_ext = 0; m_brk = 0;
    end else if (m_brk) begin
      if (b == m_held && m_ext == m_hext) begin m_held = 0; m_hext = 0; end
      m_ext = 0; m_brk = 0;
    end else begin
      e.err = 0; e.key = b; e.ext = m_ext;
      evq.push_back(e);
      m_held = b; m_hext = m_ext;
      m_ext = 0; m_brk = 0;
    end
  endfunction

  function automatic void model_err();
    ev_t e;
    e.err = 1; e.key = 0; e.ext = 0;
    evq.push_back(e);
    m_ext = 0; m_brk = 0;
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input bit [7:0] b, input bit bad_par, input bit bad_stop, input bit glitch);
    bit [10:0] bits;
    bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      ps2d = bits[i];
      if (glitch && i == 3) begin
        wait_clk(5); ps2c = 1'b0; wait_clk(2); ps2c = 1'b1; wait_clk(HALF - 7);
      end else begin
        wait_clk(HALF);
      end
      ps2c = 1'b0;
      if (i == 10) begin
        if (bad_par || bad_stop) model_err();
        else model_byte(b);
      end
      wait_clk(HALF);
      ps2c = 1'b1;
    end
    ps2d = 1'b1;
    wait_clk(3 * HALF);
    check("held", 32'(o_held), 32'(m_held));
  endtask

  // Start bit plus four data bits, then the line goes quiet
  task automatic send_partial(input bit expect_tmo);
    bit [4:0] bits;
    bits = 5'b11010;
    if (expect_tmo) model_err();
    for (int i = 0; i < 5; i++) begin
      ps2d = bits[i];
      wait_clk(HALF); ps2c = 1'b0;
      wait_clk(HALF); ps2c = 1'b1;
    end
    ps2d = 1'b1;
    if (expect_tmo) wait_clk(3 * TMO);
  endtask

  initial begin
    ev_t e;
    forever begin
      @(posedge clk);
      #1;
      if (run_chk) begin
        if (o_key_valid && o_frame_err) begin
          checks++; fails++;
          $display("FAIL both_strobes: key %0h and frame_err together", o_key);
        end
        if (o_frame_err) begin
          checks++;
          n_err++;
          if (evq.size() > 0 && evq[0].err) void'(evq.pop_front());
          else begin fails++; $display("FAIL frame_err: got unexpected error strobe expected none"); end
        end
        if (o_key_valid) begin
`ifdef PS2_AUTOREPEAT_EN
          if (!(evq.size() > 0 && !evq[0].err && evq[0].key == o_key) &&
              ((m_held != 0 && o_key == m_held && o_ext == m_hext) ||
               (m_held_prev != 0 && o_key == m_held_prev && o_ext == m_hext_prev))) begin
            checks++;
            n_rep++;
          end else
`endif
          if (evq.size() == 0 || evq[0].err) begin
            checks++; fails++;
            $display("FAIL pulse: got key %0h ext %0b expected no pulse", o_key, o_ext);
          end else begin
            e = evq.pop_front();
            check("pulse", {23'd0, o_ext, o_key}, {23'd0, e.ext, e.key});
            n_pulse++;
          end
        end else begin
          check("idle_key", {23'd0, o_ext, o_key}, 32'd0);
        end
      end
    end
  end

  initial begin
    bit [7:0] pool [12];
    bit [7:0] b;
    int base;
    pool = '{8'hE0, 8'hF0, 8'hE1, 8'h1C, 8'h1D, 8'h1B, 8'h23, 8'hAA,
             8'hFA, 8'h00, 8'h75, 8'h6B};

    wait_clk(5);
    check("rst_key", 32'(o_key), 32'h0);
    check("rst_valid", 32'(o_key_valid), 32'h0);
    check("rst_ext", 32'(o_ext), 32'h0);
    check("rst_held", 32'(o_held), 32'h0);
    check("rst_err", 32'(o_frame_err), 32'h0);
    rst_n = 1'b1;
    wait_clk(5);
    run_chk = 1;

    send_frame(8'h1C, 0, 0, 0);
    check("lit_held_1C", 32'(o_held), 32'h1C);
    check("lit_npulse1", n_pulse, 1);

    send_frame(8'hE0, 0, 0, 0);
    send_frame(8'h1C, 0, 0, 0);
    check("lit_npulse2", n_pulse, 2);
    send_frame(8'hE0, 0, 0, 0);
    send_frame(8'hF0, 0, 0, 0);
    send_frame(8'h1C, 0, 0, 0);
    check("lit_held_rel", 32'(o_held), 32'h0);
    check("lit_npulse_rel", n_pulse, 2);

    send_frame(8'h23, 1, 0, 0);
    check("lit_nerr1", n_err, 1);
    send_frame(8'h23, 0, 0, 0);
    check("lit_held_23", 32'(o_held), 32'h23);

    send_partial(1);
    check("lit_nerr_tmo", n_err, 2);
    send_frame(8'h1D, 0, 0, 0);
    check("lit_held_1D", 32'(o_held), 32'h1D);

    foreach (pool[i]) if (i < 0) b = pool[i];
    send_frame(8'hE1, 0, 0, 0);
    send_frame(8'h14, 0, 0, 0);
    send_frame(8'h77, 0, 0, 0);
    send_frame(8'hE1, 0, 0, 0);
    send_frame(8'hF0, 0, 0, 0);
    send_frame(8'h14, 0, 0, 0);
    send_frame(8'hF0, 0, 0, 0);
    send_frame(8'h77, 0, 0, 0);
    check("lit_pause_npulse", n_pulse, 4);
    send_frame(8'h1B, 0, 0, 0);
    check("lit_npulse_1B", n_pulse, 5);
    check("lit_nerr_pause", n_err, 2);

    send_frame(8'h1C, 0, 1, 0);
    check("lit_nerr_stop", n_err, 3);
    send_frame(8'h1C, 0, 0, 1);
    check("lit_held_glitch", 32'(o_held), 32'h1C);

    // Reset in the middle of a frame
    send_partial(0);
    run_chk = 0;
    rst_n = 1'b0;
    wait_clk(3);
    check("midrst_held", 32'(o_held), 32'h0);
    check("midrst_valid", 32'(o_key_valid), 32'h0);
    evq.delete();
    m_skip = 0; m_ext = 0; m_brk = 0; m_held = 0; m_hext = 0; m_held_prev = 0; m_hext_prev = 0;
    rst_n = 1'b1;
    wait_clk(5);
    run_chk = 1;
    send_frame(8'h1D, 0, 0, 0);
    check("lit_held_after_rst", 32'(o_held), 32'h1D);

`ifdef PS2_AUTOREPEAT_EN
    send_frame(8'hF0, 0, 0, 0);
    send_frame(8'h1D, 0, 0, 0);
    base = n_pulse + n_rep;
    send_frame(8'h1D, 0, 0, 0);
    wait_clk(3400);
    check("rpt_count", n_pulse + n_rep - base, 4);
    send_frame(8'hF0, 0, 0, 0);
    send_frame(8'h1D, 0, 0, 0);
    base = n_rep;
    wait_clk(3000);
    check("rpt_stopped", n_rep - base, 0);
`endif

    for (int k = 0; k < 40; k++) begin
      b = ($urandom_range(0, 4) == 0) ? 8'($urandom) : pool[$urandom_range(0, 11)];
      send_frame(b, $urandom_range(0, 9) == 0, $urandom_range(0, 14) == 0, $urandom_range(0, 7) == 0);
    end

    wait_clk(100);
    check("queue_empty", evq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
